gcd_lcm_coproc: RTL and testbench

- Parametrised iterative GCD/LCM coprocessor. Attaches beside the single-cycle RISC-V core as a memory-mapped accelerator.
- The bus-side wrapper drives the start/mode/operand inputs and reads back the result, status and step count.
- Generalises the fixed 32-bit GCD-only coprocessor in three ways:
  - configurable WIDTH;
  - a runtime GCD/LCM mode;
  - a start/busy/done handshake with overflow error and step counter.

---
 rtl/gcd_lcm_coproc.sv | 98 +++++++++
 tb/tb_gcd_lcm_coproc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_coproc.sv
// Iterative GCD/LCM coprocessor: subtractive GCD, additive LCM with overflow
// detection, start/busy/done handshake and a step counter.
module gcd_lcm_coproc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CNT_W-1:0] steps
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x, y, a_r, b_r;
  logic             mode_r;

  logic             x_lt_y;
  logic [WIDTH-1:0] lcm_src, lcm_add;
  logic [WIDTH:0]   lcm_sum;

  // LCM advances whichever running multiple is smaller; the extra sum bit is the overflow carry.
  always_comb begin
    x_lt_y  = (x < y);
    lcm_src = x_lt_y ? x : y;
    lcm_add = x_lt_y ? a_r : b_r;
    lcm_sum = {1'b0, lcm_src} + {1'b0, lcm_add};
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      steps  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x      <= op_a;
            y      <= op_b;
            a_r    <= op_a;
            b_r    <= op_b;
            mode_r <= mode;
            err    <= 1'b0;
            steps  <= '0;
            if (op_a == '0 || op_b == '0) begin
              result <= mode ? '0 : (op_a | op_b);
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (x == y) begin
            result <= x;
            state  <= DONE;
          end else if (!mode_r) begin
            if (x > y) x <= x - y;
            else       y <= y - x;
            steps <= steps + CNT_W'(1);
          end else begin
            steps <= steps + CNT_W'(1);
            if (lcm_sum[WIDTH]) begin
              result <= '0;
              err    <= 1'b1;
              state  <= DONE;
            end else if (x_lt_y) begin
              x <= lcm_sum[WIDTH-1:0];
            end else begin
              y <= lcm_sum[WIDTH-1:0];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Bench for gcd_lcm_coproc: 32-bit and 8-bit instances, directed and random
// operations checked against an arithmetic (Euclid / multiples) reference.
module tb_gcd_lcm_coproc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, mode32, busy32, done32, err32;
  logic [31:0] a32, b32, res32;
  logic [32:0] steps32;
  logic        start8, mode8, busy8, done8, err8;
  logic [7:0]  a8, b8, res8;
  logic [8:0]  steps8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  gcd_lcm_coproc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .mode(mode32), .op_a(a32), .op_b(b32),
    .busy(busy32), .done(done32), .result(res32), .err(err32), .steps(steps32)
  );

  gcd_lcm_coproc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .result(res8), .err(err8), .steps(steps8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit wide, input bit st, input bit m,
                       input longint unsigned a, input longint unsigned b);
    if (wide) begin
      start32 = st; mode32 = m; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start8 = st; mode8 = m; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic logic [63:0] rd_res(input bit wide);
    return wide ? 64'(res32) : 64'(res8);
  endfunction
  function automatic logic [63:0] rd_steps(input bit wide);
    return wide ? 64'(steps32) : 64'(steps8);
  endfunction
  function automatic logic rd_busy(input bit wide);
    return wide ? busy32 : busy8;
  endfunction
  function automatic logic rd_done(input bit wide);
    return wide ? done32 : done8;
  endfunction
  function automatic logic rd_err(input bit wide);
    return wide ? err32 : err8;
  endfunction

  // GCD steps = sum of Euclid quotients - 1. LCM steps = L/a + L/b - 2, or on overflow
  // the shorter multiple chain runs out first and the partner chain catches up past it.
  task automatic model(input int w, input bit m, input longint unsigned a, input longint unsigned b,
                       output longint unsigned res, output longint unsigned stp, output bit ov);
    longint unsigned top, p, q, t, qs, g, l, ka, kb;
    top = (64'd1 << w) - 1;
    ov  = 1'b0;
    if (a == 0 || b == 0) begin
      res = m ? 0 : (a | b);
      stp = 0;
      return;
    end
    p = a; q = b; qs = 0;
    while (q != 0) begin
      qs += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    g = p;
    if (!m) begin
      res = g;
      stp = qs - 1;
    end else begin
      l = (a / g) * b;
      if (l <= top) begin
        res = l;
        stp = l / a + l / b - 2;
      end else begin
        ov  = 1'b1;
        res = 0;
        ka  = top / a;
        kb  = top / b;
        if (ka * a < kb * b) stp = ka + (ka * a) / b;
        else                 stp = kb + (kb * b) / a;
      end
    end
  endtask

  task automatic run_op(input bit wide, input bit m, input longint unsigned a,
                        input longint unsigned b, input string tag, input bit scramble);
    longint unsigned er, es, elat;
    bit eov, busy_ok, hold_ok;
    int n;
    logic [63:0] prev;
    model(wide ? 32 : 8, m, a, b, er, es, eov);
    elat = (a == 0 || b == 0) ? 0 : (eov ? es : es + 1);
    @(negedge clk);
    prev = rd_res(wide);
    drive(wide, 1'b1, m, a, b);
    @(posedge clk);
    #1;
    drive(wide, 1'b0, m, a, b);
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (rd_done(wide) !== 1'b1 && n < 5000) begin
      if (rd_busy(wide) !== 1'b1) busy_ok = 1'b0;
      if (rd_res(wide) !== prev) hold_ok = 1'b0;
      if (scramble)
        drive(wide, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              longint'($urandom), longint'($urandom));
      @(posedge clk);
      #1;
      n++;
    end
    drive(wide, 1'b0, m, a, b);
    check({tag, ".latency"}, 64'(n), elat);
    check({tag, ".result"}, rd_res(wide), er);
    check({tag, ".err"}, 64'(rd_err(wide)), 64'(eov));
    check({tag, ".steps"}, rd_steps(wide), es);
    check({tag, ".busy_at_done"}, 64'(rd_busy(wide)), 64'd1);
    check({tag, ".busy_while_run"}, 64'(busy_ok), 64'd1);
    check({tag, ".result_held"}, 64'(hold_ok), 64'd1);
    @(posedge clk);
    #1;
    check({tag, ".idle_busy"}, 64'(rd_busy(wide)), 64'd0);
    check({tag, ".done_pulse"}, 64'(rd_done(wide)), 64'd0);
  endtask

  initial begin
    logic [9:0] busy_v, done_v;
    bit no_done;
    longint unsigned ra, rb;
    bit rm;

    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    #1;
    check("reset.busy32", 64'(busy32), 64'd0);
    check("reset.done32", 64'(done32), 64'd0);
    check("reset.result32", 64'(res32), 64'd0);
    check("reset.err32", 64'(err32), 64'd0);
    check("reset.steps32", 64'(steps32), 64'd0);
    check("reset.busy8", 64'(busy8), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(1'b1, 1'b0, 12, 8, "gcd_12_8", 1'b0);
    run_op(1'b1, 1'b1, 4, 6, "lcm_4_6", 1'b0);
    run_op(1'b1, 1'b1, 7, 7, "lcm_7_7", 1'b0);
    run_op(1'b1, 1'b0, 0, 9, "gcd_0_9", 1'b0);
    run_op(1'b1, 1'b0, 0, 0, "gcd_0_0", 1'b0);
    run_op(1'b1, 1'b1, 5, 0, "lcm_5_0", 1'b0);
    run_op(1'b0, 1'b1, 255, 254, "w8_lcm_255_254", 1'b0);
    run_op(1'b0, 1'b0, 255, 254, "w8_gcd_255_254", 1'b0);
    run_op(1'b1, 1'b0, 1000, 3, "gcd_1000_3_scrambled", 1'b1);

    // Asynchronous reset in the middle of a long GCD.
    run_op(1'b1, 1'b0, 12, 8, "pre_reset", 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1000, 3);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1000, 3);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort.busy", 64'(busy32), 64'd0);
    check("abort.done", 64'(done32), 64'd0);
    check("abort.result", 64'(res32), 64'd0);
    check("abort.err", 64'(err32), 64'd0);
    check("abort.steps", 64'(steps32), 64'd0);
    no_done = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done32 !== 1'b0 || busy32 !== 1'b0) no_done = 1'b0;
    end
    check("abort.quiet", 64'(no_done), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    run_op(1'b1, 1'b0, 1000, 3, "post_reset_gcd_1000_3", 1'b0);

    // start held high: one IDLE cycle between back-to-back operations.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 12, 8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      busy_v[i] = busy32;
      done_v[i] = done32;
    end
    drive(1'b1, 1'b0, 1'b0, 12, 8);
    check("hold_start.busy_pattern", 64'(busy_v), 64'(10'b0111101111));
    check("hold_start.done_pattern", 64'(done_v), 64'(10'b0100001000));
    check("hold_start.result", 64'(res32), 64'd4);
    check("hold_start.steps", 64'(steps32), 64'd2);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      rm = 1'($urandom_range(1, 0));
      ra = ($urandom_range(9, 0) == 0) ? 0 : longint'($urandom_range(300, 1));
      rb = ($urandom_range(9, 0) == 0) ? 0 : longint'($urandom_range(300, 1));
      run_op(1'b1, rm, ra, rb, $sformatf("rand32_%0d", i), 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      rm = 1'($urandom_range(1, 0));
      ra = longint'($urandom_range(255, 0));
      rb = longint'($urandom_range(255, 1));
      run_op(1'b0, rm, ra, rb, $sformatf("rand8_%0d", i), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
